// File: rtl/dmem_request_ctrl_if.sv
// Request/response bus between the memory-stage initiator (master) and the
// multi-cycle data memory responder (slave).
interface dmem_request_ctrl_if #(
  parameter int WORD_W = 64,
  parameter int IDX_W  = 7
);
  logic              req_valid;
  logic              req_we;
  logic [IDX_W-1:0]  req_index;
  logic [WORD_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_index, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_index, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/dmem_request_ctrl.sv
// Memory-stage initiator: turns mem_read/mem_write into a valid/ready request,
// stalls the pipeline until the data memory responds or times out.
// Optional: define MISALIGN_TRAP_EN to reject addresses with nonzero [2:0].
module dmem_request_ctrl #(
  parameter int WORD_W  = 64,
  parameter int DEPTH   = 100,
  parameter int IDX_W   = 7,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] mem_address,
  input  logic [WORD_W-1:0] mem_write_data,
  output logic [WORD_W-1:0] mem_read_data,
  output logic              stall,
  output logic              done,
  output logic              err,
  dmem_request_ctrl_if.master dmem
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [WORD_W-4:0] DEPTH_L  = (WORD_W-3)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_q, we_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              bad_addr;

  // Full-width compare so that any set upper address bit counts as out of range.
`ifdef MISALIGN_TRAP_EN
  assign bad_addr = (mem_address[WORD_W-1:3] >= DEPTH_L) || (|mem_address[2:0]);
`else
  assign bad_addr = (mem_address[WORD_W-1:3] >= DEPTH_L);
  logic unused_low_bits;
  assign unused_low_bits = ^mem_address[2:0];
`endif

  // NOTE: every variable is given its hold value before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = we_q;
    index_d = index_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stall   = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall = mem_read | mem_write;
        if (mem_read | mem_write) begin
          we_d    = mem_write;
          index_d = mem_address[IDX_W+2:3];
          wdata_d = mem_write_data;
          err_d   = bad_addr;
          state_d = bad_addr ? S_DONE : S_REQ;
        end
      end

      S_REQ: begin
        stall = 1'b1;
        if (dmem.req_ready) begin
          count_d = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        stall   = 1'b1;
        count_d = count_q + CNT_W'(1);
        // A response arriving on the last allowed cycle still wins over the timeout.
        if (dmem.resp_valid) begin
          if (!we_q) rdata_d = dmem.resp_rdata;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (count_q == CNT_LAST) begin
          if (!we_q) rdata_d = '1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      we_q    <= 1'b0;
      index_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      index_q <= index_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign dmem.req_valid = (state_q == S_REQ);
  assign dmem.req_we    = we_q;
  assign dmem.req_index = index_q;
  assign dmem.req_wdata = wdata_q;
  assign done           = (state_q == S_DONE);
  assign err            = err_q;
  assign mem_read_data  = rdata_q;

endmodule

// File: tb/tb_dmem_request_ctrl.sv
// Self-checking bench for dmem_request_ctrl: directed vector table, a reset
// mid-access sequence, and randomized operations against a transaction model.
module tb_dmem_request_ctrl;

  localparam int WORD_W  = 64;
  localparam int DEPTH   = 100;
  localparam int IDX_W   = 7;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_read, mem_write;
  logic [WORD_W-1:0] mem_address, mem_write_data, mem_read_data;
  logic              stall, done, err;

  dmem_request_ctrl_if #(.WORD_W(WORD_W), .IDX_W(IDX_W)) dmem ();

  dmem_request_ctrl #(
    .WORD_W(WORD_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .stall         (stall),
    .done          (done),
    .err           (err),
    .dmem          (dmem)
  );

  always #5 clk = ~clk;

  // One pipeline memory operation plus how the responder treats it.
  // d: cycles req_ready stays low while req_valid is up.
  // n: WAIT cycle (1-based) carrying resp_valid; 0 means never.
  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          d;
    int          n;
    logic        noise;
  } op_t;

  typedef struct {
    int          stall;
    logic        req;
    logic [6:0]  index;
    logic        we;
    logic [63:0] wdata;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  typedef struct {
    logic        done_seen;
    int          stall_cnt;
    logic        req_seen;
    logic [6:0]  index;
    logic        we;
    logic [63:0] wdata;
    logic        stable;
    logic        err;
    logic [63:0] rdata;
    logic        done_stall;
    logic        done_after;
  } obs_t;

  typedef struct {
    op_t  op;
    exp_t exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] shadow_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic op_t mk_op(logic rd, logic wr, logic [63:0] addr, logic [63:0] wdata,
                                int d, int n, logic [63:0] rdata, logic noise);
    op_t o;
    o.rd = rd; o.wr = wr; o.addr = addr; o.wdata = wdata;
    o.d = d; o.n = n; o.rdata = rdata; o.noise = noise;
    return o;
  endfunction

  function automatic exp_t mk_exp(int st, logic req, logic [6:0] idx, logic we,
                                  logic [63:0] wdata, logic e, logic [63:0] rdata);
    exp_t x;
    x.stall = st; x.req = req; x.index = idx; x.we = we;
    x.wdata = wdata; x.err = e; x.rdata = rdata;
    return x;
  endfunction

  // Transaction-level reference: rejected accesses take one stall cycle, accepted
  // ones take IDLE + (d+1) REQ cycles + the WAIT length, capped by the timeout.
  function automatic exp_t model(op_t op, logic [63:0] prev);
    exp_t x;
    logic bad;
    int   wait_len;
    bad = (op.addr / 8) >= 64'(DEPTH);
`ifdef MISALIGN_TRAP_EN
    if (op.addr % 8 != 0) bad = 1'b1;
`endif
    x.index = 7'((op.addr / 8) % 128);
    x.we    = op.wr;
    x.wdata = op.wdata;
    if (bad) begin
      x.stall = 1; x.req = 1'b0; x.err = 1'b1; x.rdata = prev;
    end else begin
      x.req = 1'b1;
      if (op.n >= 1 && op.n <= TIMEOUT) begin
        wait_len = op.n;
        x.err    = 1'b0;
        x.rdata  = op.wr ? prev : op.rdata;
      end else begin
        wait_len = TIMEOUT;
        x.err    = 1'b1;
        x.rdata  = op.wr ? prev : 64'hFFFF_FFFF_FFFF_FFFF;
      end
      x.stall = 1 + (op.d + 1) + wait_len;
    end
    return x;
  endfunction

  // Starts in IDLE at posedge+1, plays pipeline and responder, ends in IDLE at posedge+1.
  task automatic run_op(input op_t op, output obs_t ob);
    int   rv_cyc;
    int   wait_cyc;
    logic hs;
    ob.done_seen = 1'b0; ob.stall_cnt = 0; ob.req_seen = 1'b0; ob.index = '0;
    ob.we = 1'b0; ob.wdata = '0; ob.stable = 1'b1; ob.err = 1'b0; ob.rdata = '0;
    ob.done_stall = 1'b0; ob.done_after = 1'b0;
    rv_cyc = 0; wait_cyc = 0; hs = 1'b0;
    mem_read = op.rd; mem_write = op.wr; mem_address = op.addr; mem_write_data = op.wdata;
    for (int cyc = 0; cyc < 200 && !ob.done_seen; cyc++) begin
      dmem.req_ready  = dmem.req_valid && (rv_cyc >= op.d);
      dmem.resp_valid = 1'b0;
      dmem.resp_rdata = {$urandom, $urandom};
      if (hs) begin
        wait_cyc++;
        if (wait_cyc == op.n) begin
          dmem.resp_valid = 1'b1;
          dmem.resp_rdata = op.rdata;
        end
      end else if (dmem.req_valid && op.noise) begin
        dmem.resp_valid = 1'b1;
      end
      #1;
      if (stall) ob.stall_cnt++;
      if (dmem.req_valid) begin
        if (!ob.req_seen) begin
          ob.index = dmem.req_index; ob.we = dmem.req_we; ob.wdata = dmem.req_wdata;
        end else if (ob.index !== dmem.req_index || ob.we !== dmem.req_we ||
                     ob.wdata !== dmem.req_wdata) begin
          ob.stable = 1'b0;
        end
        ob.req_seen = 1'b1;
        rv_cyc++;
        if (dmem.req_ready) hs = 1'b1;
      end
      if (done) begin
        ob.done_seen = 1'b1; ob.err = err; ob.rdata = mem_read_data; ob.done_stall = stall;
      end
      @(posedge clk); #1;
    end
    mem_read = 1'b0; mem_write = 1'b0; dmem.req_ready = 1'b0; dmem.resp_valid = 1'b0;
    #1;
    ob.done_after = done;
  endtask

  task automatic compare(input string tag, input exp_t e, input obs_t ob);
    check({tag, ".done_seen"}, 64'(ob.done_seen), 64'd1);
    check({tag, ".stall_cycles"}, 64'(ob.stall_cnt), 64'(e.stall));
    check({tag, ".req_seen"}, 64'(ob.req_seen), 64'(e.req));
    if (e.req) begin
      check({tag, ".req_index"}, 64'(ob.index), 64'(e.index));
      check({tag, ".req_we"}, 64'(ob.we), 64'(e.we));
      check({tag, ".req_wdata"}, ob.wdata, e.wdata);
      check({tag, ".req_stable"}, 64'(ob.stable), 64'd1);
    end
    check({tag, ".err"}, 64'(ob.err), 64'(e.err));
    check({tag, ".read_data"}, ob.rdata, e.rdata);
    check({tag, ".stall_in_done"}, 64'(ob.done_stall), 64'd0);
    check({tag, ".done_one_cycle"}, 64'(ob.done_after), 64'd0);
  endtask

  vec_t vecs[10];
  obs_t ob;
  exp_t ex;
  op_t  op;

  initial begin
    vecs[0] = '{mk_op(1, 0, 64'h10, 64'h0, 0, 2, 64'hDEADBEEF, 0),
                mk_exp(4, 1, 7'd2, 0, 64'h0, 0, 64'hDEADBEEF)};
    vecs[1] = '{mk_op(0, 1, 64'h40, 64'h55, 3, 1, 64'h0, 0),
                mk_exp(6, 1, 7'd8, 1, 64'h55, 0, 64'hDEADBEEF)};
    vecs[2] = '{mk_op(1, 0, 64'd800, 64'h0, 0, 1, 64'h1, 0),
                mk_exp(1, 0, 7'd0, 0, 64'h0, 1, 64'hDEADBEEF)};
    vecs[3] = '{mk_op(1, 0, 64'h0, 64'h0, 0, 0, 64'h0, 0),
                mk_exp(18, 1, 7'd0, 0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF)};
    vecs[4] = '{mk_op(1, 1, 64'h18, 64'hA5, 1, 3, 64'h1234, 1),
                mk_exp(6, 1, 7'd3, 1, 64'hA5, 0, 64'hFFFF_FFFF_FFFF_FFFF)};
    vecs[5] = '{mk_op(1, 0, 64'h8, 64'h0, 0, 16, 64'hCAFE, 0),
                mk_exp(18, 1, 7'd1, 0, 64'h0, 0, 64'hCAFE)};
`ifdef MISALIGN_TRAP_EN
    vecs[6] = '{mk_op(1, 0, 64'h0C, 64'h0, 0, 1, 64'h77, 0),
                mk_exp(1, 0, 7'd1, 0, 64'h0, 1, 64'hCAFE)};
    vecs[7] = '{mk_op(1, 0, 64'd792, 64'h0, 2, 1, 64'h99, 0),
                mk_exp(5, 1, 7'd99, 0, 64'h0, 0, 64'h99)};
`else
    vecs[6] = '{mk_op(1, 0, 64'h0C, 64'h0, 0, 1, 64'h77, 0),
                mk_exp(3, 1, 7'd1, 0, 64'h0, 0, 64'h77)};
    vecs[7] = '{mk_op(1, 0, 64'd792, 64'h0, 2, 1, 64'h99, 0),
                mk_exp(5, 1, 7'd99, 0, 64'h0, 0, 64'h99)};
`endif
    vecs[8] = '{mk_op(0, 1, 64'h1000_0000_0000_0010, 64'h3, 0, 1, 64'h0, 0),
                mk_exp(1, 0, 7'd0, 0, 64'h0, 1, 64'h99)};
    vecs[9] = '{mk_op(0, 1, 64'h20, 64'hBEEF, 0, 0, 64'h0, 1),
                mk_exp(18, 1, 7'd4, 1, 64'hBEEF, 1, 64'h99)};

    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_write_data = '0;
    dmem.req_ready = 1'b0; dmem.resp_valid = 1'b0; dmem.resp_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.stall", 64'(stall), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.err", 64'(err), 64'd0);
    check("reset.req_valid", 64'(dmem.req_valid), 64'd0);
    check("reset.req_we", 64'(dmem.req_we), 64'd0);
    check("reset.req_index", 64'(dmem.req_index), 64'd0);
    check("reset.req_wdata", dmem.req_wdata, 64'd0);
    check("reset.read_data", mem_read_data, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, ob);
      compare($sformatf("vec%0d", i), vecs[i].exp, ob);
    end

    // Reset while waiting for a response; the late response must be ignored.
    mem_read = 1'b1; mem_address = 64'h28; dmem.req_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rst_mid.stall_before", 64'(stall), 64'd1);
    #2;
    reset = 1'b1; mem_read = 1'b0; dmem.req_ready = 1'b0;
    #1;
    check("rst_mid.stall", 64'(stall), 64'd0);
    check("rst_mid.req_valid", 64'(dmem.req_valid), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    check("rst_mid.read_data", mem_read_data, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      dmem.resp_valid = 1'b1; dmem.resp_rdata = 64'h1111_2222_3333_4444;
      #1;
      check($sformatf("rst_mid.late_resp%0d.done", c), 64'(done), 64'd0);
      check($sformatf("rst_mid.late_resp%0d.stall", c), 64'(stall), 64'd0);
      check($sformatf("rst_mid.late_resp%0d.req_valid", c), 64'(dmem.req_valid), 64'd0);
      check($sformatf("rst_mid.late_resp%0d.read_data", c), mem_read_data, 64'd0);
      @(posedge clk); #1;
    end
    dmem.resp_valid = 1'b0;
    shadow_rdata = '0;

    for (int i = 0; i < 40; i++) begin
      int kind, sel;
      kind = $urandom_range(0, 2);
      sel  = $urandom_range(0, 9);
      op.rd = (kind != 1);
      op.wr = (kind != 0);
      if (sel < 6)      op.addr = 64'($urandom_range(0, DEPTH - 1)) * 8;
      else if (sel < 8) op.addr = 64'($urandom_range(0, DEPTH - 1)) * 8 + 64'($urandom_range(1, 7));
      else if (sel < 9) op.addr = 64'($urandom_range(DEPTH, 127)) * 8;
      else              op.addr = {$urandom, $urandom};
      op.wdata = {$urandom, $urandom};
      op.rdata = {$urandom, $urandom};
      op.d     = $urandom_range(0, 3);
      op.n     = $urandom_range(0, 20);
      op.noise = 1'($urandom_range(0, 1));
      ex = model(op, shadow_rdata);
      run_op(op, ob);
      compare($sformatf("rand%0d", i), ex, ob);
      shadow_rdata = ex.rdata;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
